// File: rtl/array_22_arb_if.sv
// Request/response and SRAM-port bundle for the two-client arbiter in front of the 1024x300 macro.
// The slave modport is the arbiter's view; master is the clients-plus-macro view.
interface array_22_arb_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 300,
    parameter int LANES  = 10
);
    logic              a_req_valid;
    logic              a_req_ready;
    logic              a_req_write;
    logic [ADDR_W-1:0] a_req_addr;
    logic [LANES-1:0]  a_req_mask;
    logic [DATA_W-1:0] a_req_wdata;
    logic              a_resp_valid;
    logic              a_resp_ready;
    logic [DATA_W-1:0] a_resp_data;

    logic              b_req_valid;
    logic              b_req_ready;
    logic              b_req_write;
    logic [ADDR_W-1:0] b_req_addr;
    logic [LANES-1:0]  b_req_mask;
    logic [DATA_W-1:0] b_req_wdata;
    logic              b_resp_valid;
    logic              b_resp_ready;
    logic [DATA_W-1:0] b_resp_data;

    logic              mem_en;
    logic              mem_wmode;
    logic [ADDR_W-1:0] mem_addr;
    logic [LANES-1:0]  mem_wmask;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  a_req_valid, a_req_write, a_req_addr, a_req_mask, a_req_wdata, a_resp_ready,
        output a_req_ready, a_resp_valid, a_resp_data,
        input  b_req_valid, b_req_write, b_req_addr, b_req_mask, b_req_wdata, b_resp_ready,
        output b_req_ready, b_resp_valid, b_resp_data,
        output mem_en, mem_wmode, mem_addr, mem_wmask, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output a_req_valid, a_req_write, a_req_addr, a_req_mask, a_req_wdata, a_resp_ready,
        input  a_req_ready, a_resp_valid, a_resp_data,
        output b_req_valid, b_req_write, b_req_addr, b_req_mask, b_req_wdata, b_resp_ready,
        input  b_req_ready, b_resp_valid, b_resp_data,
        input  mem_en, mem_wmode, mem_addr, mem_wmask, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/array_22_arb.sv
// Round-robin arbiter/sequencer sharing one SRAM RW port between requesters A (index 0) and B (index 1).
// Reads land in a per-requester response register two cycles after grant.
module array_22_arb #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 300,
    parameter int LANES  = 10
) (
    input logic           clock,
    input logic           reset,
    array_22_arb_if.slave bus
);
    logic [1:0]             req_valid;
    logic [1:0]             req_write;
    logic [1:0][ADDR_W-1:0] req_addr;
    logic [1:0][LANES-1:0]  req_mask;
    logic [1:0][DATA_W-1:0] req_wdata;
    logic [1:0]             resp_ready;

    logic [1:0]             elig;
    logic [1:0]             grant_vec;
    logic [1:0]             pend;
    logic [1:0]             resp_valid;
    logic [1:0][DATA_W-1:0] resp_data;
    logic                   rr_ptr;
    logic                   both;
    logic                   grant;
    logic                   win;

    logic                   mem_en;
    logic                   mem_wmode;
    logic [ADDR_W-1:0]      mem_addr;
    logic [LANES-1:0]       mem_wmask;
    logic [DATA_W-1:0]      mem_wdata;

    assign req_valid  = {bus.b_req_valid, bus.a_req_valid};
    assign req_write  = {bus.b_req_write, bus.a_req_write};
    assign req_addr   = {bus.b_req_addr, bus.a_req_addr};
    assign req_mask   = {bus.b_req_mask, bus.a_req_mask};
    assign req_wdata  = {bus.b_req_wdata, bus.a_req_wdata};
    assign resp_ready = {bus.b_resp_ready, bus.a_resp_ready};

    // A read waits until its previous read has been returned and dequeued;
    // this keeps the capture and dequeue from ever colliding.
    always_comb begin
        elig      = '0;
        grant_vec = '0;
        mem_wmode = 1'b0;
        mem_addr  = '0;
        mem_wmask = '0;
        mem_wdata = '0;
        for (int i = 0; i < 2; i++) begin
            elig[i] = req_valid[i] && (req_write[i] || (!resp_valid[i] && !pend[i]));
        end
        both  = &elig;
        grant = (|elig) && !reset;
        win   = both ? rr_ptr : elig[1];
        if (grant) begin
            grant_vec[win] = 1'b1;
            mem_wmode      = req_write[win];
            mem_addr       = req_addr[win];
            mem_wmask      = req_mask[win];
            mem_wdata      = req_wdata[win];
        end
        mem_en = grant;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr <= 1'b0;
            pend   <= '0;
        end else begin
            if (grant && both) rr_ptr <= ~win;
            pend <= grant_vec & ~req_write;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_valid <= '0;
            resp_data  <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (pend[i]) begin
                    resp_valid[i] <= 1'b1;
                    resp_data[i]  <= bus.mem_rdata;
                end else if (resp_valid[i] && resp_ready[i]) begin
                    resp_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.a_req_ready  = grant_vec[0];
    assign bus.b_req_ready  = grant_vec[1];
    assign bus.a_resp_valid = resp_valid[0];
    assign bus.b_resp_valid = resp_valid[1];
    assign bus.a_resp_data  = resp_data[0];
    assign bus.b_resp_data  = resp_data[1];
    assign bus.mem_en       = mem_en;
    assign bus.mem_wmode    = mem_wmode;
    assign bus.mem_addr     = mem_addr;
    assign bus.mem_wmask    = mem_wmask;
    assign bus.mem_wdata    = mem_wdata;
endmodule

// File: tb/tb_array_22_arb.sv
// Bench for array_22_arb: SRAM macro model, directed scenarios, then random traffic
// checked every cycle against a queue-based reference of grants, memory and responses.
module tb_array_22_arb;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 300;
    localparam int LANES  = 10;
    localparam int LW     = DATA_W / LANES;
    typedef logic [DATA_W-1:0] word_t;
    typedef struct {
        word_t data;
        int    due;
    } resp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    array_22_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANES(LANES)) bus ();
    array_22_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANES(LANES)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    logic             rv[2];
    logic             rw[2];
    logic             rr[2];
    logic [ADDR_W-1:0] ra[2];
    logic [LANES-1:0] rm[2];
    word_t            rd[2];

    assign bus.a_req_valid  = rv[0];
    assign bus.a_req_write  = rw[0];
    assign bus.a_req_addr   = ra[0];
    assign bus.a_req_mask   = rm[0];
    assign bus.a_req_wdata  = rd[0];
    assign bus.a_resp_ready = rr[0];
    assign bus.b_req_valid  = rv[1];
    assign bus.b_req_write  = rw[1];
    assign bus.b_req_addr   = ra[1];
    assign bus.b_req_mask   = rm[1];
    assign bus.b_req_wdata  = rd[1];
    assign bus.b_resp_ready = rr[1];

    int checks = 0;
    int errors = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic word_t rnd_word();
        word_t w;
        for (int l = 0; l < LANES; l++) w[l*LW +: LW] = LW'($urandom);
        return w;
    endfunction

    function automatic logic rdy(input int i);
        return (i == 0) ? bus.a_req_ready : bus.b_req_ready;
    endfunction

    function automatic logic rvld(input int i);
        return (i == 0) ? bus.a_resp_valid : bus.b_resp_valid;
    endfunction

    function automatic word_t rdat(input int i);
        return (i == 0) ? bus.a_resp_data : bus.b_resp_data;
    endfunction

    // SRAM macro: masked write, registered read; garbage on rdata when not reading
    word_t macro_mem [1<<ADDR_W];
    word_t rdata_q;
    assign bus.mem_rdata = rdata_q;
    always @(posedge clock) begin
        if (bus.mem_en && bus.mem_wmode)
            for (int l = 0; l < LANES; l++)
                if (bus.mem_wmask[l]) macro_mem[bus.mem_addr][l*LW +: LW] <= bus.mem_wdata[l*LW +: LW];
        rdata_q <= (bus.mem_en && !bus.mem_wmode) ? macro_mem[bus.mem_addr] : rnd_word();
    end

    // Reference: memory image in program order, one timestamped response queue per requester
    word_t ref_mem [1<<ADDR_W];
    resp_t rq[2][$];
    int    cyc = 0;
    int    favour = 0;
    logic  d_grant = 1'b0;
    logic  d_both = 1'b0;
    int    d_win = 0;
    logic  d_take[2] = '{1'b0, 1'b0};

    always @(negedge clock) begin
        logic  can[2];
        logic  ev[2];
        word_t exp_data;
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                rq[i].delete();
                d_take[i] = 1'b0;
            end
            favour  = 0;
            d_grant = 1'b0;
            chk1("rst_ready_a", bus.a_req_ready, 1'b0);
            chk1("rst_ready_b", bus.b_req_ready, 1'b0);
            chk1("rst_mem_en", bus.mem_en, 1'b0);
            chk1("rst_resp_valid_a", bus.a_resp_valid, 1'b0);
            chk1("rst_resp_valid_b", bus.b_resp_valid, 1'b0);
        end else begin
            for (int i = 0; i < 2; i++) begin
                can[i] = rv[i] && (rw[i] || rq[i].size() == 0);
                ev[i]  = rq[i].size() != 0 && cyc >= rq[i][0].due;
            end
            d_grant = can[0] || can[1];
            d_both  = can[0] && can[1];
            d_win   = d_both ? favour : (can[1] ? 1 : 0);
            chk1("ready_a", bus.a_req_ready, d_grant && d_win == 0);
            chk1("ready_b", bus.b_req_ready, d_grant && d_win == 1);
            chk1("mem_en", bus.mem_en, d_grant);
            chk1("mem_wmode", bus.mem_wmode, d_grant ? rw[d_win] : 1'b0);
            chkw("mem_addr", word_t'(bus.mem_addr), d_grant ? word_t'(ra[d_win]) : '0);
            chkw("mem_wmask", word_t'(bus.mem_wmask), d_grant ? word_t'(rm[d_win]) : '0);
            chkw("mem_wdata", bus.mem_wdata, d_grant ? rd[d_win] : '0);
            for (int i = 0; i < 2; i++) begin
                chk1(i == 0 ? "resp_valid_a" : "resp_valid_b", rvld(i), ev[i]);
                if (ev[i]) begin
                    exp_data = rq[i][0].data;
                    chkw(i == 0 ? "resp_data_a" : "resp_data_b", rdat(i), exp_data);
                end
                d_take[i] = ev[i] && rr[i];
            end
        end
    end

    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) if (d_take[i]) void'(rq[i].pop_front());
            if (d_grant) begin
                if (rw[d_win]) begin
                    for (int l = 0; l < LANES; l++)
                        if (rm[d_win][l]) ref_mem[ra[d_win]][l*LW +: LW] = rd[d_win][l*LW +: LW];
                end else begin
                    rq[d_win].push_back('{data: ref_mem[ra[d_win]], due: cyc + 2});
                end
                if (d_both) favour = 1 - d_win;
            end
        end
        cyc = cyc + 1;
    end

    int en_cnt = 0;
    always @(negedge clock) if (bus.mem_en) en_cnt = en_cnt + 1;

    // Holds a request until granted, then drops valid just after the following edge
    task automatic req(input int i, input logic w, input logic [ADDR_W-1:0] a,
                       input logic [LANES-1:0] m, input word_t d);
        int n;
        rv[i] = 1'b1; rw[i] = w; ra[i] = a; rm[i] = m; rd[i] = d;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!rdy(i) && n < 50);
        chk1("grant_wait", rdy(i), 1'b1);
        @(posedge clock); #1;
        rv[i] = 1'b0;
    endtask

    task automatic wait_resp(input int i);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!rvld(i) && n < 20);
        chk1("resp_wait", rvld(i), 1'b1);
    endtask

    task automatic take(input int i);
        @(posedge clock); #1;
        rr[i] = 1'b1;
        @(posedge clock); #1;
        rr[i] = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clock); #2;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        @(posedge clock); #1;
    endtask

    localparam word_t P1 = {10{30'h1234567}};
    localparam word_t P2 = {{9{30'h3FFFFFFF}}, 30'h0};
    localparam word_t P3 = {10{30'h2AAAAAAA}};
    localparam word_t P4 = {10{30'h0F0F0F0F}};
    localparam word_t P5 = {10{30'h15555555}};

    logic acc[2];

    initial begin
        for (int k = 0; k < (1 << ADDR_W); k++) begin
            macro_mem[k] = '0;
            ref_mem[k]   = '0;
        end
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; rw[i] = 1'b0; rr[i] = 1'b0;
            ra[i] = '0; rm[i] = '0; rd[i] = '0;
            acc[i] = 1'b0;
        end
        repeat (3) @(posedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        chk1("post_rst_resp_valid_a", bus.a_resp_valid, 1'b0);
        chk1("post_rst_resp_valid_b", bus.b_resp_valid, 1'b0);
        chkw("post_rst_resp_data_a", bus.a_resp_data, '0);
        chk1("post_rst_mem_en", bus.mem_en, 1'b0);
        @(posedge clock); #1;

        // write then read back
        en_cnt = 0;
        req(0, 1'b1, 10'h005, 10'h3FF, P1);
        req(0, 1'b0, 10'h005, 10'h000, '0);
        @(negedge clock);
        chk1("t1_not_yet", bus.a_resp_valid, 1'b0);
        @(negedge clock);
        chk1("t1_resp_valid", bus.a_resp_valid, 1'b1);
        chkw("t1_resp_data", bus.a_resp_data, P1);
        chkw("t1_en_cycles", word_t'(en_cnt), word_t'(2));
        take(0);

        // partial mask
        req(0, 1'b1, 10'h010, 10'h3FF, '1);
        req(0, 1'b1, 10'h010, 10'h001, '0);
        req(0, 1'b0, 10'h010, 10'h000, '0);
        wait_resp(0);
        chkw("t2_partial", bus.a_resp_data, P2);
        take(0);

        // contention from a fresh reset
        do_reset();
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b1; rw[i] = 1'b1;
            ra[i] = ADDR_W'($urandom_range(64, 127)); rm[i] = LANES'($urandom); rd[i] = rnd_word();
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            chk1("t3_both_ready", bus.a_req_ready && bus.b_req_ready, 1'b0);
            chk1("t3_turn", rdy(k % 2), 1'b1);
            @(posedge clock); #1;
            for (int i = 0; i < 2; i++) rd[i] = rnd_word();
        end
        rv[0] = 1'b0; rv[1] = 1'b0;

        // backpressure on B
        req(1, 1'b1, 10'h3FF, 10'h3FF, P3);
        req(1, 1'b0, 10'h3FF, 10'h000, '0);
        rv[1] = 1'b1; rw[1] = 1'b0; ra[1] = 10'h3FF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk1("t4_blocked", bus.b_req_ready, 1'b0);
            if (k > 0) begin
                chk1("t4_held_valid", bus.b_resp_valid, 1'b1);
                chkw("t4_held_data", bus.b_resp_data, P3);
            end
            @(posedge clock); #1;
        end
        rr[1] = 1'b1;
        @(negedge clock);
        chk1("t4_no_lookahead", bus.b_req_ready, 1'b0);
        @(posedge clock); #1;
        rr[1] = 1'b0;
        @(negedge clock);
        chk1("t4_regrant", bus.b_req_ready, 1'b1);
        @(posedge clock); #1;
        rv[1] = 1'b0;
        wait_resp(1);
        take(1);

        // A read and B write to the same word in one cycle
        req(0, 1'b1, 10'h020, 10'h3FF, P4);
        do_reset();
        rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 10'h020; rm[0] = '0;
        rv[1] = 1'b1; rw[1] = 1'b1; ra[1] = 10'h020; rm[1] = 10'h3FF; rd[1] = P5;
        @(negedge clock);
        chk1("t5_a_first", bus.a_req_ready, 1'b1);
        chk1("t5_b_waits", bus.b_req_ready, 1'b0);
        @(posedge clock); #1;
        rv[0] = 1'b0;
        @(negedge clock);
        chk1("t5_b_next", bus.b_req_ready, 1'b1);
        @(posedge clock); #1;
        rv[1] = 1'b0;
        @(negedge clock);
        chk1("t5_a_valid", bus.a_resp_valid, 1'b1);
        chkw("t5_a_old_data", bus.a_resp_data, P4);
        take(0);
        req(0, 1'b0, 10'h020, 10'h000, '0);
        wait_resp(0);
        chkw("t5_a_new_data", bus.a_resp_data, P5);
        take(0);

        // reset lands the cycle after a read grant
        req(0, 1'b0, 10'h005, 10'h000, '0);
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        @(posedge clock); #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk1("t6_no_resp", bus.a_resp_valid, 1'b0);
        end
        chkw("t6_resp_data_a", bus.a_resp_data, '0);
        chk1("t6_resp_valid_b", bus.b_resp_valid, 1'b0);
        @(posedge clock); #1;
        rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 10'h100; rm[0] = 10'h3FF; rd[0] = rnd_word();
        rv[1] = 1'b1; rw[1] = 1'b1; ra[1] = 10'h101; rm[1] = 10'h3FF; rd[1] = rnd_word();
        @(negedge clock);
        chk1("t6_favour_a", bus.a_req_ready, 1'b1);
        chk1("t6_b_waits", bus.b_req_ready, 1'b0);
        @(posedge clock); #1;
        rv[0] = 1'b0; rv[1] = 1'b0;

        // random traffic on a small address set to force hazards
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!rv[i] || acc[i]) begin
                    rv[i] = ($urandom % 3) != 0;
                    rw[i] = $urandom % 2;
                    ra[i] = (($urandom % 8) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom % 8);
                    rm[i] = LANES'($urandom);
                    rd[i] = rnd_word();
                end
                rr[i] = ($urandom % 2) != 0;
            end
            if (n % 1000 == 999) begin
                #1 reset = 1'b1;
                @(posedge clock);
                #2 reset = 1'b0;
                #1;
            end
            @(negedge clock);
            for (int i = 0; i < 2; i++) acc[i] = rv[i] && rdy(i);
            @(posedge clock); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/array_22_arb.md
Name: array_22_arb

Overview:
- Two-requester arbiter and sequencer for the 1024x300 single-port SRAM macro (one RW port, 10 write-mask lanes of 30 bits, 1-cycle registered read latency).
- Shares the RW port between requesters A and B using ready/valid handshakes and round-robin fairness.
- Captures read data into a per-requester response register with backpressure.
- Sits between the two cache-side clients and the macro; no other logic drives the macro port.

Parameters:
- ADDR_W, 10, SRAM address width (depth 2^ADDR_W).
- DATA_W, 300, SRAM word width.
- LANES, 10, write-mask lanes; lane width = DATA_W/LANES, divisibility required.

Ports:
- clock  in  1  single clock for the block and the macro.
- reset  in  1  asynchronous, active-high reset.
- a_req_valid / b_req_valid  in  1  request present.
- a_req_ready / b_req_ready  out  1  request accepted this cycle when valid&&ready.
- a_req_write / b_req_write  in  1  1=write, 0=read.
- a_req_addr / b_req_addr  in  ADDR_W  word address.
- a_req_mask / b_req_mask  in  LANES  write lane enables; ignored for reads.
- a_req_wdata / b_req_wdata  in  DATA_W  write data.
- a_resp_valid / b_resp_valid  out  1  read data held in response register.
- a_resp_ready / b_resp_ready  in  1  consumer takes the response.
- a_resp_data / b_resp_data  out  DATA_W  read data.
- mem_en  out  1  to macro RW0_en.
- mem_wmode  out  1  to macro RW0_wmode.
- mem_addr  out  ADDR_W  to macro RW0_addr.
- mem_wmask  out  LANES  to macro RW0_wmask.
- mem_wdata  out  DATA_W  to macro RW0_wdata.
- mem_rdata  in  DATA_W  from macro RW0_rdata.

Behaviour:
- State: rr_ptr (0=A favoured), pend_a, pend_b (read issued last cycle), a_resp_valid/b_resp_valid, a_resp_data/b_resp_data.
- Reset (async): rr_ptr=0, pend_*=0, *_resp_valid=0, *_resp_data=0. While reset is high: mem_en=0, *_req_ready=0.
- Eligibility:
  - Writes are always eligible when valid.
  - A read from X is eligible only if X_resp_valid==0 and pend_X==0.
  - There is no resp_ready look-ahead, so max read throughput is one per 3 cycles per requester.
- Grant (combinational):
  - If exactly one requester is eligible, it wins.
  - If both are eligible, the winner is the requester selected by rr_ptr.
  - Winner's req_ready=1; the other's req_ready=0.
  - On any grant while both were eligible, rr_ptr <= loser. A single eligible grant leaves rr_ptr unchanged.
- Macro drive:
  - mem_en=1 iff a grant occurs.
  - mem_wmode, mem_addr, mem_wmask and mem_wdata come from the winner.
  - When there is no grant, mem_wmode=0, and mem_addr/wmask/wdata=0.
- Read pipeline:
  - Grant of a read at cycle T sets pend_X at edge T.
  - At cycle T+1, mem_rdata is valid. At edge T+1: X_resp_data <= mem_rdata, X_resp_valid <= 1, pend_X <= 0.
  - Request-to-response latency is 2 cycles: resp_valid is high in T+2.
- Response: X_resp_valid clears on the edge where X_resp_valid && X_resp_ready. resp_data holds stable while valid.
- Ordering: single port gives program order. A write granted at T followed by a read of the same address at T+1 returns the new data. Masked-off lanes retain their old values.
- Simultaneous events:
  - A response dequeue and a new capture for the same requester cannot collide, because eligibility blocks it.
  - A dequeue in cycle C lets that requester's read become eligible in C+1.
- Reset mid-operation: an in-flight read is discarded with no response. A write granted in the reset-assert cycle completes in the macro only if its edge precedes reset; there is no replay.
- No combinational path from resp_ready to req_ready, and no path from mem_rdata to any output.

Test Plan:
- Single write then read:
  - Stimulus: A writes addr 0x005, mask 0x3FF, data {10{30'h1234567}}; next cycle A reads 0x005.
  - Response: a_resp_valid in read-grant+2 with that data; mem_en high exactly 2 cycles.
- Partial mask:
  - Stimulus: write 0x010 all-ones with mask 0x3FF, then write zeros with mask 0x001, then read 0x010.
  - Response: lane0 = 0, lanes1-9 = 30'h3FFFFFFF.
- Contention:
  - Stimulus: A and B both hold valid writes continuously for 6 cycles after reset.
  - Response: grants alternate A,B,A,B,A,B; no cycle has both ready.
- Backpressure:
  - Stimulus: B reads 0x3FF with b_resp_ready=0 for 5 cycles, and issues a second read request meanwhile.
  - Response: second read not granted (b_req_ready=0) until the cycle after resp is taken; resp_data stable throughout.
- Interleaved:
  - Stimulus: A read and B write arrive in the same cycle with rr_ptr=0.
  - Response: A granted first, B next cycle; A response equals pre-write contents.
- Reset mid-read:
  - Stimulus: assert reset asynchronously the cycle after A's read grant.
  - Response: a_resp_valid stays 0; after release, all outputs are at reset values and rr_ptr favours A.
